// File: rtl/wb_sram_slave.sv
// Wishbone classic-cycle slave backed by a 32-bit word RAM with programmable ack latency,
// saturating read/write counters and a sticky abort flag.
module wb_sram_slave #(
  parameter int MEM_AW      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        abort_seen
);

  localparam int         DEPTH    = 1 << MEM_AW;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              commit, abort;
  logic              req;
  logic [MEM_AW-1:0] idx;
  logic [31:0]       mem [DEPTH];

  assign req      = wb_cyc_i & wb_stb_i;
  assign idx      = wb_adr_i[MEM_AW+1:2];
  assign wb_ack_o = (state == ST_ACK);

  // commit marks the edge that enters ACK: RAM write, read capture and counting
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = ST_ACK;
            commit    = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
          abort     = 1'b1;
        end else if (cnt == 4'd0) begin
          state_nxt = ST_ACK;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      wb_dat_o   <= 32'd0;
      rd_count   <= 16'd0;
      wr_count   <= 16'd0;
      abort_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (commit) begin
        if (wb_we_i) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          wb_dat_o <= mem[idx];
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
      end
      if (abort) abort_seen <= 1'b1;
    end
  end

  // RAM keeps its contents through reset; the reset branch only blocks writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
    end else if (commit && wb_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

endmodule
